// File: rtl/fp16_normalizer_if.sv
// Handshake bundle between the sign/op resolution stage, the FP16 normalizer and its consumer.
interface fp16_normalizer_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [MAN_W+1:0]       mant_in;
  logic [EXP_W-1:0]       exp_in;
  logic                   sign_in;
  logic                   op_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output in_valid, mant_in, exp_in, sign_in, op_in, out_ready,
    input  in_ready, out_valid, result, overflow, underflow
  );

  modport slave (
    input  in_valid, mant_in, exp_in, sign_in, op_in, out_ready,
    output in_ready, out_valid, result, overflow, underflow
  );
endinterface

// File: rtl/fp16_normalizer.sv
// Post-add/sub normalization: one right shift on carry-out, iterative left shifts on cancellation,
// then truncating pack into {sign, exp, frac} with overflow/underflow flags.
module fp16_normalizer #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  fp16_normalizer_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, EVAL, SHIFT, PACK, DONE} state_t;

  // Exponent carries one extra bit so the all-ones (infinity) code is seen before packing.
  localparam logic [EXP_W:0] E_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t               state;
  logic [MAN_W+1:0]     m;
  logic [EXP_W:0]       e;
  logic                 s;
  logic                 op;
  logic                 ovf;
  logic                 zro;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [EXP_W+MAN_W:0] result_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic [EXP_W:0]       e_inc;
  logic [EXP_W:0]       e_dec;
  logic [MAN_W+1:0]     m_shl;

  assign e_inc = e + E_ONE;
  assign e_dec = e - E_ONE;
  assign m_shl = m << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m           <= '0;
      e           <= '0;
      s           <= 1'b0;
      op          <= 1'b0;
      ovf         <= 1'b0;
      zro         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && in_ready_q) begin
          m          <= bus.mant_in;
          e          <= (bus.exp_in == '0) ? E_ONE : {1'b0, bus.exp_in};
          s          <= bus.sign_in;
          op         <= bus.op_in;
          ovf        <= 1'b0;
          zro        <= 1'b0;
          in_ready_q <= 1'b0;
          state      <= EVAL;
        end
        EVAL: begin
          if (m == '0) begin
            // Exact cancellation yields +0; a true zero sum keeps its sign.
            if (op) s <= 1'b0;
            zro   <= 1'b1;
            state <= PACK;
          end else if (m[MAN_W+1]) begin
            m     <= m >> 1;
            e     <= e_inc;
            ovf   <= (e_inc == E_MAX);
            state <= PACK;
          end else if (m[MAN_W]) begin
            state <= PACK;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (e == E_ONE) begin
            state <= PACK;
          end else begin
            m <= m_shl;
            e <= e_dec;
            if (m_shl[MAN_W] || e_dec == E_ONE) state <= PACK;
          end
        end
        PACK: begin
          out_valid_q <= 1'b1;
          overflow_q  <= 1'b0;
          underflow_q <= 1'b0;
          if (zro) begin
            result_q <= {s, {(EXP_W+MAN_W){1'b0}}};
          end else if (ovf) begin
            result_q   <= {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow_q <= 1'b1;
          end else if (m[MAN_W]) begin
            result_q <= {s, e[EXP_W-1:0], m[MAN_W-1:0]};
          end else begin
            result_q    <= {s, {EXP_W{1'b0}}, m[MAN_W-1:0]};
            underflow_q <= 1'b1;
          end
          state <= DONE;
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fp16_normalizer.sv
// Directed + random checks of fp16_normalizer against a value-level normalization model.
module tb_fp16_normalizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  fp16_normalizer_if bus ();

  fp16_normalizer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: locate leading one, decide shift amount from the exponent headroom, pack.
  function automatic void model(input int mi, input int ex, input int s, input int op,
                                output int res, output int ov, output int un, output int lat);
    int m, e, p, need;
    m = mi; e = (ex == 0) ? 1 : ex;
    ov = 0; un = 0; lat = 2;
    if (m == 0) begin
      res = (op != 0) ? 0 : (s << 15);
      return;
    end
    p = 0;
    for (int i = 0; i < 12; i++) if ((m >> i) & 1) p = i;
    if (p == 11) begin
      m = m >> 1; e = e + 1;
      if (e == 31) begin
        ov = 1; res = (s << 15) | 'h7C00;
        return;
      end
    end else if (p < 10) begin
      need = 10 - p;
      if (e == 1) lat = lat + 1;
      else if (need <= e - 1) begin m = m << need; e = e - need; lat = lat + need; end
      else begin m = m << (e - 1); lat = lat + e - 1; e = 1; end
    end
    if (m >= 1024) res = (s << 15) | (e << 10) | (m & 1023);
    else begin res = (s << 15) | (m & 1023); un = 1; end
  endfunction

  task automatic run(input int m, input int ex, input int s, input int op, input int hold);
    int res, ov, un, lat, cyc;
    logic [15:0] held;
    model(m, ex, s, op, res, ov, un, lat);
    @(negedge clk);
    bus.mant_in  = 12'(m);
    bus.exp_in   = 5'(ex);
    bus.sign_in  = s[0];
    bus.op_in    = op[0];
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_in_ready", 32'(bus.in_ready), 0);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (bus.out_valid !== 1'b1 && cyc < 40);
    chk("latency", cyc, lat);
    chk("result", 32'(bus.result), res);
    chk("overflow", 32'(bus.overflow), ov);
    chk("underflow", 32'(bus.underflow), un);
    held = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_result", 32'(bus.result), 32'(held));
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("post_valid", 32'(bus.out_valid), 0);
    chk("post_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    int m, sh;
    bus.in_valid = 1'b0; bus.mant_in = '0; bus.exp_in = '0;
    bus.sign_in = 1'b0; bus.op_in = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_underflow", 32'(bus.underflow), 0);

    run('h400, 15, 0, 0, 0);
    run('h800, 15, 0, 0, 0);
    run('h800, 30, 0, 0, 0);
    run('h800, 30, 1, 0, 0);
    run('h001, 15, 1, 1, 0);
    run('h000, 15, 1, 1, 0);
    run('h000, 15, 1, 0, 0);
    run('h010, 3, 0, 1, 0);
    run('h010, 1, 0, 1, 0);
    run('h100, 0, 1, 1, 0);
    run('h200, 2, 0, 1, 0);
    run('h3FF, 12, 0, 0, 5);

    for (int n = 0; n < 40; n++) begin
      m  = $urandom_range(0, 4095);
      sh = $urandom_range(0, 11);
      run(m >> sh, $urandom_range(0, 30), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 2));
    end

    // Abort mid-shift: reset must discard the pending result.
    @(negedge clk);
    bus.mant_in = 12'h001; bus.exp_in = 5'd15; bus.sign_in = 1'b1; bus.op_in = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 1);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_result", 32'(bus.result), 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_stale", 32'(bus.out_valid), 0);
    end
    run('h004, 20, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
